// File: rtl/mst_wr_arb_pkg.sv
// Shared types and constants for the two-requester master-FIFO write arbiter.
// Word layout: [17] command/start, [16] last, [15:0] payload.
package mst_wr_arb_pkg;
    localparam int WORD_W  = 18;
    localparam int WB_CMD  = 17;
    localparam int WB_LAST = 16;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_G0   = 2'd1,
        ARB_G1   = 2'd2
    } arb_state_t;
endpackage

// File: rtl/mst_wr_arb_rr.sv
// Two-way round-robin pick; rr remembers the last granted index (1 after reset so rq0 wins first).
// Combinational pick, rr updates only when a grant is actually taken.
module mst_wr_arb_rr (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic req0,
    input  logic req1,
    input  logic take,
    output logic pick
);
    logic rr;

    always_comb begin
        pick = req1;
        if (req0 && req1) begin
            pick = ~rr;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            rr <= 1'b1;
        end else if (take) begin
            rr <= pick;
        end
    end
endmodule

// File: rtl/mst_wr_arb.sv
// Packet-granular arbiter merging two requester streams into one master FIFO.
// Latency 1 (accepted word -> mst_wr_en next cycle); ready follows ~mst_full while granted.
module mst_wr_arb
    import mst_wr_arb_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [WORD_W-1:0] rq0_din,
    input  logic              rq0_valid,
    output logic              rq0_ready,
    input  logic [WORD_W-1:0] rq1_din,
    input  logic              rq1_valid,
    output logic              rq1_ready,
    output logic [WORD_W-1:0] mst_din,
    output logic              mst_wr_en,
    input  logic              mst_full,
    output logic [CNT_W-1:0]  rq0_pkt_cnt,
    output logic [CNT_W-1:0]  rq1_pkt_cnt,
    output logic              rq0_err,
    output logic              rq1_err
);
    arb_state_t        state;
    arb_state_t        state_nxt;
    logic              first;
    logic              take;
    logic              pick;
    logic              sel1;
    logic [WORD_W-1:0] sel_din;
    logic              sel_vld;
    logic              acc;
    logic              bad_first;
    logic              fwd;
    logic              done;

    assign take = (state == ARB_IDLE) && (rq0_valid || rq1_valid);

    mst_wr_arb_rr u_rr (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .req0    (rq0_valid),
        .req1    (rq1_valid),
        .take    (take),
        .pick    (pick)
    );

    assign sel1    = (state == ARB_G1);
    assign sel_din = sel1 ? rq1_din : rq0_din;
    assign sel_vld = sel1 ? rq1_valid : rq0_valid;

    always_comb begin
        state_nxt = state;
        rq0_ready = 1'b0;
        rq1_ready = 1'b0;
        acc       = 1'b0;
        bad_first = 1'b0;
        fwd       = 1'b0;
        done      = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (take) begin
                    state_nxt = pick ? ARB_G1 : ARB_G0;
                end
            end
            ARB_G0, ARB_G1: begin
                rq0_ready = !sel1 && !mst_full;
                rq1_ready = sel1 && !mst_full;
                acc       = sel_vld && !mst_full;
                // Only the opening word of a grant must carry the command bit.
                bad_first = acc && first && !sel_din[WB_CMD];
                fwd       = acc && !bad_first;
                done      = fwd && sel_din[WB_LAST];
                if (bad_first || done) begin
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            first       <= 1'b1;
            mst_wr_en   <= 1'b0;
            mst_din     <= '0;
            rq0_pkt_cnt <= '0;
            rq1_pkt_cnt <= '0;
            rq0_err     <= 1'b0;
            rq1_err     <= 1'b0;
        end else begin
            mst_wr_en <= fwd;
            if (fwd) begin
                mst_din <= sel_din;
            end
            if (state == ARB_IDLE) begin
                first <= 1'b1;
            end else if (acc) begin
                first <= 1'b0;
            end
            if (done) begin
                if (sel1) rq1_pkt_cnt <= rq1_pkt_cnt + CNT_W'(1);
                else      rq0_pkt_cnt <= rq0_pkt_cnt + CNT_W'(1);
            end
            if (bad_first) begin
                if (sel1) rq1_err <= 1'b1;
                else      rq0_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mst_wr_arb.sv
// Directed bench for mst_wr_arb: single packet, contention, backpressure, framing error, wrap and reset.
module tb_mst_wr_arb;
    import mst_wr_arb_pkg::*;

    logic        sys_clk;
    logic        sys_rst;
    logic [17:0] rq0_din, rq1_din;
    logic        rq0_valid, rq1_valid;
    logic        rq0_ready, rq1_ready;
    logic [17:0] mst_din;
    logic        mst_wr_en;
    logic        mst_full;
    logic [7:0]  rq0_pkt_cnt, rq1_pkt_cnt;
    logic        rq0_err, rq1_err;

    int          nchk = 0;
    int          nfail = 0;
    int          cyc = 0;
    int          last_rise = 0;
    logic [17:0] wq[$];
    int          wc[$];

    mst_wr_arb #(.CNT_W(8)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .rq0_din     (rq0_din),
        .rq0_valid   (rq0_valid),
        .rq0_ready   (rq0_ready),
        .rq1_din     (rq1_din),
        .rq1_valid   (rq1_valid),
        .rq1_ready   (rq1_ready),
        .mst_din     (mst_din),
        .mst_wr_en   (mst_wr_en),
        .mst_full    (mst_full),
        .rq0_pkt_cnt (rq0_pkt_cnt),
        .rq1_pkt_cnt (rq1_pkt_cnt),
        .rq0_err     (rq0_err),
        .rq1_err     (rq1_err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (mst_wr_en === 1'b1) begin
            wq.push_back(mst_din);
            wc.push_back(cyc);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) until the driven word is accepted at the coming rising edge.
    task automatic wait_acc(input int r);
        int n;
        n = 0;
        #4;
        while (((r == 0) ? rq0_ready : rq1_ready) !== 1'b1 && n < 200) begin
            @(negedge sys_clk);
            #4;
            n++;
        end
        chk($sformatf("acc_timeout_rq%0d", r), 32'(n < 200), 32'd1);
    endtask

    task automatic send(input int r, input logic [17:0] w[$]);
        foreach (w[i]) begin
            @(negedge sys_clk);
            if (r == 0) begin
                rq0_din = w[i]; rq0_valid = 1'b1;
            end else begin
                rq1_din = w[i]; rq1_valid = 1'b1;
            end
            if (i == 0) last_rise = cyc;
            wait_acc(r);
        end
        @(negedge sys_clk);
        if (r == 0) rq0_valid = 1'b0;
        else        rq1_valid = 1'b0;
    endtask

    task automatic do_reset();
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b1;
    endtask

    initial begin
        logic [17:0] q0[$];
        logic [17:0] q1[$];
        logic [17:0] exp_c[$];
        int          t0;

        sys_rst = 1'b0; mst_full = 1'b0;
        rq0_din = '0; rq1_din = '0; rq0_valid = 1'b0; rq1_valid = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("rst_wr_en", 32'(mst_wr_en), 32'd0);
        chk("rst_din", 32'(mst_din), 32'h0);
        chk("rst_rdy", 32'({rq0_ready, rq1_ready}), 32'd0);
        chk("rst_cnt", 32'({rq0_pkt_cnt, rq1_pkt_cnt}), 32'd0);
        chk("rst_err", 32'({rq0_err, rq1_err}), 32'd0);
        chk("rst_state", 32'(dut.state), 32'(ARB_IDLE));
        sys_rst = 1'b1;

        // Single 3-word packet on rq0
        wq.delete(); wc.delete();
        q0 = {18'h290ff, 18'h01234, 18'h1abcd};
        send(0, q0);
        t0 = last_rise;
        repeat (2) @(negedge sys_clk);
        chk("single_nwr", 32'(wq.size()), 32'd3);
        if (wq.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("single_w%0d", i), 32'(wq[i]), 32'(q0[i]));
                chk($sformatf("single_cyc%0d", i), 32'(wc[i]), 32'(t0 + 2 + i));
            end
        end
        chk("single_cnt0", 32'(rq0_pkt_cnt), 32'd1);

        // Contention from reset: two back-to-back packets per requester
        wq.delete(); wc.delete();
        q0 = {18'h2a000, 18'h0a001, 18'h0a002, 18'h1a003,
              18'h2a010, 18'h0a011, 18'h0a012, 18'h1a013};
        q1 = {18'h2b000, 18'h0b001, 18'h0b002, 18'h1b003,
              18'h2b010, 18'h0b011, 18'h0b012, 18'h1b013};
        exp_c = {18'h2a000, 18'h0a001, 18'h0a002, 18'h1a003,
                 18'h2b000, 18'h0b001, 18'h0b002, 18'h1b003,
                 18'h2a010, 18'h0a011, 18'h0a012, 18'h1a013,
                 18'h2b010, 18'h0b011, 18'h0b012, 18'h1b013};
        sys_rst = 1'b0;
        fork
            send(0, q0);
            send(1, q1);
            begin
                repeat (2) @(negedge sys_clk);
                #4 chk("rst_rdy_vld", 32'({rq0_ready, rq1_ready}), 32'd0);
                @(negedge sys_clk);
                sys_rst = 1'b1;
            end
        join
        repeat (2) @(negedge sys_clk);
        chk("cont_nwr", 32'(wq.size()), 32'd16);
        if (wq.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                chk($sformatf("cont_w%0d", i), 32'(wq[i]), 32'(exp_c[i]));
            end
        end
        chk("cont_cnt", 32'({rq0_pkt_cnt, rq1_pkt_cnt}), 32'h0202);

        // Backpressure: mst_full for 5 cycles after word 2
        wq.delete(); wc.delete();
        @(negedge sys_clk); rq0_din = 18'h2c000; rq0_valid = 1'b1;
        wait_acc(0);
        @(negedge sys_clk); rq0_din = 18'h0c001;
        wait_acc(0);
        @(negedge sys_clk); rq0_din = 18'h0c002; mst_full = 1'b1;
        #1 chk("bp_rdy0", 32'(rq0_ready), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge sys_clk);
            chk($sformatf("bp_wr%0d", k), 32'(mst_wr_en), 32'd0);
            if (k < 5) begin
                #1 chk($sformatf("bp_rdy%0d", k), 32'(rq0_ready), 32'd0);
            end
        end
        mst_full = 1'b0;
        wait_acc(0);
        @(negedge sys_clk); rq0_din = 18'h1c003;
        wait_acc(0);
        @(negedge sys_clk); rq0_valid = 1'b0;
        repeat (2) @(negedge sys_clk);
        chk("bp_nwr", 32'(wq.size()), 32'd4);
        if (wq.size() == 4) begin
            chk("bp_w2", 32'(wq[2]), 32'h0c002);
            chk("bp_w3", 32'(wq[3]), 32'h1c003);
        end
        chk("bp_cnt0", 32'(rq0_pkt_cnt), 32'd3);

        // Framing error on rq1, then a good single-word packet
        do_reset();
        wq.delete(); wc.delete();
        q1 = {18'h05555};
        send(1, q1);
        repeat (2) @(negedge sys_clk);
        chk("ferr_nwr", 32'(wq.size()), 32'd0);
        chk("ferr_err", 32'({rq0_err, rq1_err}), 32'b01);
        chk("ferr_state", 32'(dut.state), 32'(ARB_IDLE));
        q1 = {18'h30001};
        send(1, q1);
        repeat (2) @(negedge sys_clk);
        chk("ferr_nwr2", 32'(wq.size()), 32'd1);
        if (wq.size() == 1) chk("ferr_w0", 32'(wq[0]), 32'h30001);
        chk("ferr_cnt1", 32'(rq1_pkt_cnt), 32'd1);
        chk("ferr_sticky", 32'(rq1_err), 32'd1);

        // 256 single-word packets wrap the rq0 counter
        wq.delete(); wc.delete();
        q0.delete();
        for (int i = 0; i < 256; i++) q0.push_back({2'b11, 16'(i)});
        send(0, q0);
        repeat (2) @(negedge sys_clk);
        chk("wrap_nwr", 32'(wq.size()), 32'd256);
        if (wq.size() == 256) chk("wrap_last", 32'(wq[255]), 32'h300ff);
        chk("wrap_cnt0", 32'(rq0_pkt_cnt), 32'd0);

        // Reset mid-packet
        wq.delete(); wc.delete();
        @(negedge sys_clk); rq0_din = 18'h2d000; rq0_valid = 1'b1;
        wait_acc(0);
        @(negedge sys_clk); rq0_din = 18'h0d001; sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("mrst_wr_en", 32'(mst_wr_en), 32'd0);
        chk("mrst_cnt", 32'({rq0_pkt_cnt, rq1_pkt_cnt}), 32'd0);
        chk("mrst_err", 32'({rq0_err, rq1_err}), 32'd0);
        chk("mrst_state", 32'(dut.state), 32'(ARB_IDLE));
        chk("mrst_din", 32'(mst_din), 32'h0);
        rq0_valid = 1'b0; sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        chk("mrst_nwr", 32'(wq.size()), 32'd1);
        if (wq.size() == 1) chk("mrst_w0", 32'(wq[0]), 32'h2d000);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
